dist_search_ctrl: RTL and testbench
===================================

Name: dist_search_ctrl

Overview:
- Sequencing stage directly upstream and downstream of the matrix distance calculator.
- Walks a candidate index range and presents each index to the candidate-matrix source.
- Pulses the calculator's ready input, waits for its finished strobe, and compares each returned dist2.
- Tracks the minimum distance and its index, with early exit on a threshold hit and a timeout guard on a stalled calculator.

Parameters:
- IDX_W, 16, width of candidate index and count.
- DIST_W, 38, width of distance values; matches the calculator dist2 output.
- TIMEOUT, 15, max cycles in WAIT before error; must be >= 2.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset (reset==0 resets on rising clk).
- start  in  1  one-cycle search request; ignored unless idle.
- num_cand  in  IDX_W  candidate count; sampled on accepted start.
- threshold  in  DIST_W  early-exit bound; sampled on accepted start.
- cand_idx  out  IDX_W  index presented to matrix source; matrices must be valid one cycle later and held while busy.
- calc_ready  out  1  one-cycle pulse to calculator ready.
- calc_finished  in  1  calculator finished strobe.
- calc_dist2  in  DIST_W  calculator result, valid when calc_finished=1.
- best_dist  out  DIST_W  minimum distance found.
- best_idx  out  IDX_W  index of best_dist.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle completion pulse.
- hit  out  1  search ended by threshold; held until next start.
- error  out  1  search ended by timeout; held until next start.
- second_dist  out  DIST_W  runner-up distance (optional feature).
- second_idx  out  IDX_W  runner-up index (optional feature).

Behaviour:
- Reset values: cand_idx=0, calc_ready=0, busy=0, done=0, hit=0, error=0, best_dist=all-ones, best_idx=0, second_dist=all-ones, second_idx=0. FSM goes to IDLE.
- Reset mid-search aborts immediately; no done pulse.
- FSM states: IDLE, SETUP, ISSUE, WAIT, FINISH.
- IDLE:
  - On start: latch num_cand and threshold; clear hit and error; set best_dist and second_dist to all-ones, best_idx and second_idx to 0; cand_idx=0; busy=1.
  - If num_cand==0, go to FINISH; otherwise go to SETUP.
- SETUP: one settle cycle for the matrix source (1-cycle read latency); go to ISSUE.
- ISSUE: calc_ready=1 for exactly this cycle; clear timeout counter; go to WAIT.
- WAIT:
  - Count cycles.
  - On calc_finished, compare calc_dist2:
    - If calc_dist2 < best_dist (strict, so the lower index wins ties), update best_dist and best_idx.
    - If calc_dist2 <= threshold, set hit=1 and go to FINISH.
    - Else if cand_idx == num_cand-1, go to FINISH.
    - Else increment cand_idx and go to SETUP.
  - If the counter reaches TIMEOUT without calc_finished: error=1, go to FINISH; best_* keep the values from completed candidates.
- FINISH: done=1 for one cycle, busy=0, go to IDLE. Results hold until the next accepted start.
- calc_finished outside WAIT is ignored.
- start while busy is ignored.
- The threshold check uses the current sample, so hit also applies when that sample ties best_dist.
- Calculator latency is 1 cycle, so nominal cost is 3 cycles/candidate.
- Nominal total latency, start to done: 3*num_cand+1 cycles; num_cand==0 gives 2 cycles.
- cand_idx never wraps: the maximum num_cand of 2^IDX_W-1 ends at index 2^IDX_W-2.
- Comparisons are unsigned on DIST_W bits.

Optional Feature:
- Macro DIST_RUNNER_UP_EN.
- Defined: also track the second-smallest distance.
  - New best: the old best moves to second_*.
  - Else if calc_dist2 < second_dist: update second_*.
- Undefined: second_dist is tied all-ones, second_idx tied 0; no comparator logic.

Test Plan:
- num_cand=4, threshold=0; calculator returns 500, 200, 300, 200 -> best_dist=200, best_idx=1, hit=0, done at cycle 13 after start.
- num_cand=5, threshold=100; returns 400, 90, ... -> hit=1 after idx 1, best_dist=90, best_idx=1, only 2 calc_ready pulses.
- num_cand=0 -> done 2 cycles after start, best_dist all-ones, no calc_ready pulse.
- Calculator never asserts finished, TIMEOUT=15 -> error=1, done pulse, best_dist all-ones.
- reset=0 asserted in WAIT of idx 2 -> next cycle all outputs at reset values, no done; a new start with num_cand=1, result 7 -> best_dist=7.
- DIST_RUNNER_UP_EN defined; returns 50, 30, 40 -> best 30/idx1, second 40/idx2. Undefined -> second_dist all-ones.

Source files
------------

// File: rtl/dist_search_ctrl.sv
// Candidate search sequencer around the matrix distance calculator: walks indices, tracks the minimum dist2.
// Optional runner-up tracking is enabled by defining DIST_RUNNER_UP_EN.
module dist_search_ctrl #(
  parameter int IDX_W   = 16,
  parameter int DIST_W  = 38,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [IDX_W-1:0]  num_cand,
  input  logic [DIST_W-1:0] threshold,
  output logic [IDX_W-1:0]  cand_idx,
  output logic              calc_ready,
  input  logic              calc_finished,
  input  logic [DIST_W-1:0] calc_dist2,
  output logic [DIST_W-1:0] best_dist,
  output logic [IDX_W-1:0]  best_idx,
  output logic              busy,
  output logic              done,
  output logic              hit,
  output logic              error,
  output logic [DIST_W-1:0] second_dist,
  output logic [IDX_W-1:0]  second_idx
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ISSUE,
    WAIT,
    FINISH
  } state_t;

  state_t            state;
  logic [IDX_W-1:0]  last_idx;
  logic [DIST_W-1:0] thr_q;
  logic [CNT_W-1:0]  wait_cnt;
  logic              new_best;
  logic              last_cand;
  logic              thr_hit;

  always_comb begin
    new_best  = calc_dist2 < best_dist;
    thr_hit   = calc_dist2 <= thr_q;
    last_cand = cand_idx == last_idx;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      cand_idx   <= '0;
      calc_ready <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      hit        <= 1'b0;
      error      <= 1'b0;
      best_dist  <= '1;
      best_idx   <= '0;
      last_idx   <= '0;
      thr_q      <= '0;
      wait_cnt   <= '0;
    end else begin
      done       <= 1'b0;
      calc_ready <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            last_idx  <= num_cand - 1'b1;
            thr_q     <= threshold;
            hit       <= 1'b0;
            error     <= 1'b0;
            best_dist <= '1;
            best_idx  <= '0;
            cand_idx  <= '0;
            busy      <= 1'b1;
            state     <= (num_cand == '0) ? FINISH : SETUP;
          end
        end
        SETUP: begin
          calc_ready <= 1'b1;
          state      <= ISSUE;
        end
        ISSUE: begin
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          if (calc_finished) begin
            if (new_best) begin
              best_dist <= calc_dist2;
              best_idx  <= cand_idx;
            end
            if (thr_hit || last_cand) begin
              hit   <= thr_hit;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= FINISH;
            end else begin
              cand_idx <= cand_idx + 1'b1;
              state    <= SETUP;
            end
          end else if (wait_cnt == CNT_LAST) begin
            error <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= FINISH;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        FINISH: begin
          // Arriving from IDLE (empty search) busy is still set: spend one extra cycle raising done here.
          if (busy) begin
            busy <= 1'b0;
            done <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DIST_RUNNER_UP_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      second_dist <= '1;
      second_idx  <= '0;
    end else if (state == IDLE && start) begin
      second_dist <= '1;
      second_idx  <= '0;
    end else if (state == WAIT && calc_finished) begin
      if (new_best) begin
        second_dist <= best_dist;
        second_idx  <= best_idx;
      end else if (calc_dist2 < second_dist) begin
        second_dist <= calc_dist2;
        second_idx  <= cand_idx;
      end
    end
  end
`else
  assign second_dist = '1;
  assign second_idx  = '0;
`endif

endmodule

// File: tb/tb_dist_search_ctrl.sv
// Scoreboard bench for dist_search_ctrl: a calculator model answers calc_ready, a reference model predicts each search.
// Runner-up expectations follow DIST_RUNNER_UP_EN when defined.
module tb_dist_search_ctrl;
  localparam int IDX_W   = 16;
  localparam int DIST_W  = 38;
  localparam int TIMEOUT = 15;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic [IDX_W-1:0]  num_cand = '0;
  logic [DIST_W-1:0] threshold = '0;
  logic [IDX_W-1:0]  cand_idx;
  logic              calc_ready;
  logic              calc_finished;
  logic [DIST_W-1:0] calc_dist2;
  logic [DIST_W-1:0] best_dist;
  logic [IDX_W-1:0]  best_idx;
  logic              busy, done, hit, error;
  logic [DIST_W-1:0] second_dist;
  logic [IDX_W-1:0]  second_idx;

  dist_search_ctrl #(.IDX_W(IDX_W), .DIST_W(DIST_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .start(start), .num_cand(num_cand), .threshold(threshold),
    .cand_idx(cand_idx), .calc_ready(calc_ready), .calc_finished(calc_finished),
    .calc_dist2(calc_dist2), .best_dist(best_dist), .best_idx(best_idx), .busy(busy),
    .done(done), .hit(hit), .error(error), .second_dist(second_dist), .second_idx(second_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DIST_W-1:0] best;
    logic [DIST_W-1:0] sec;
    int                bidx;
    int                sidx;
    bit                hit;
    bit                err;
    int                rdy;
    int                lat;
  } exp_t;

  exp_t              expq[$];
  logic [DIST_W-1:0] dist_mem [0:63];
  int                stall_idx = -1;
  int                tests = 0, fails = 0;
  int                cyc = 0, st_cyc = 0, rdy_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: scan candidates in order, strict-min with runner-up, stop on threshold or stall.
  function automatic exp_t model(input int n, input logic [DIST_W-1:0] thr, input int stall);
    exp_t e;
    logic [DIST_W-1:0] d;
    e.best = '1; e.sec = '1; e.bidx = 0; e.sidx = 0;
    e.hit = 0; e.err = 0; e.rdy = 0; e.lat = 2;
    for (int i = 0; i < n; i++) begin
      e.rdy++;
      if (i == stall) begin
        e.err = 1;
        e.lat = 3 * i + 3 + TIMEOUT;
        return e;
      end
      d = dist_mem[i];
      if (d < e.best) begin
        e.sec = e.best; e.sidx = e.bidx;
        e.best = d; e.bidx = i;
      end else if (d < e.sec) begin
        e.sec = d; e.sidx = i;
      end
      e.lat = 3 * i + 4;
      if (d <= thr) begin
        e.hit = 1;
        return e;
      end
    end
    return e;
  endfunction

  // Calculator: one-cycle latency after sampling calc_ready; never answers at stall_idx.
  initial begin
    bit pend = 0;
    int pidx = 0;
    calc_finished = 1'b0;
    calc_dist2 = '0;
    forever begin
      @(posedge clk); #1;
      calc_finished = 1'b0;
      if (pend) begin
        calc_finished = 1'b1;
        calc_dist2 = dist_mem[pidx];
        pend = 0;
      end
      if (calc_ready && reset && int'(cand_idx) != stall_idx) begin
        pend = 1;
        pidx = int'(cand_idx[5:0]);
      end
    end
  end

  // Monitor: compares each done pulse against the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (calc_ready) rdy_cnt++;
      if (done) begin
        if (expq.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_done: got 1 expected 0");
        end else begin
          e = expq.pop_front();
          check("best_dist", 64'(best_dist), 64'(e.best));
          check("best_idx", 64'(best_idx), 64'(e.bidx));
          check("hit", 64'(hit), 64'(e.hit));
          check("error", 64'(error), 64'(e.err));
          check("busy_at_done", 64'(busy), 64'd0);
          check("ready_pulses", 64'(rdy_cnt), 64'(e.rdy));
          check("latency", 64'(cyc - st_cyc), 64'(e.lat));
`ifdef DIST_RUNNER_UP_EN
          check("second_dist", 64'(second_dist), 64'(e.sec));
          check("second_idx", 64'(second_idx), 64'(e.sidx));
`else
          check("second_dist", 64'(second_dist), {64{1'b0}} | {{(64-DIST_W){1'b0}}, {DIST_W{1'b1}}});
          check("second_idx", 64'(second_idx), 64'd0);
`endif
        end
      end
    end
  end

  task automatic launch(input int n, input logic [DIST_W-1:0] thr, input int stall, input bit poke);
    @(negedge clk);
    stall_idx = stall;
    expq.push_back(model(n, thr, stall));
    num_cand = IDX_W'(n);
    threshold = thr;
    start = 1'b1;
    st_cyc = cyc;
    rdy_cnt = 0;
    @(negedge clk);
    start = 1'b0;
    if (poke) begin
      @(negedge clk);
      if (busy) begin
        num_cand = IDX_W'(7);
        threshold = '1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    end
  endtask

  task automatic wait_done();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (expq.size() == 0) return;
    end
    tests++; fails++;
    $display("FAIL done_timeout: got 0 expected 1");
    expq.delete();
  endtask

  task automatic run(input int n, input logic [DIST_W-1:0] thr, input int stall, input bit poke);
    launch(n, thr, stall, poke);
    wait_done();
  endtask

  initial begin
    logic [63:0] tmp;
    int n;
    logic [DIST_W-1:0] thr;
    int stall;
    bit found;
    for (int i = 0; i < 64; i++) dist_mem[i] = DIST_W'(1000 + i);
    repeat (3) @(negedge clk);
    check("rst_best_dist", 64'(best_dist), {{(64-DIST_W){1'b0}}, {DIST_W{1'b1}}});
    check("rst_best_idx", 64'(best_idx), 64'd0);
    check("rst_flags", {60'd0, busy, done, hit, error}, 64'd0);
    check("rst_ready_idx", {47'd0, calc_ready, cand_idx}, 64'd0);
    reset = 1'b1;
    @(negedge clk);

    dist_mem[0] = 500; dist_mem[1] = 200; dist_mem[2] = 300; dist_mem[3] = 200;
    run(4, '0, -1, 0);
    dist_mem[0] = 400; dist_mem[1] = 90; dist_mem[2] = 10; dist_mem[3] = 5; dist_mem[4] = 1;
    run(5, DIST_W'(100), -1, 0);
    run(0, '0, -1, 0);
    run(3, '0, 0, 0);
    dist_mem[0] = 50; dist_mem[1] = 30; dist_mem[2] = 40;
    run(3, '0, -1, 1);
    dist_mem[0] = 60; dist_mem[1] = 20; dist_mem[2] = 80;
    run(4, '0, 2, 0);

    // Reset asserted during WAIT of index 2 must abort with no done pulse.
    launch(5, '0, -1, 0);
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(posedge clk); #1;
      if (calc_ready && cand_idx == 2) found = 1;
    end
    check("reached_idx2", 64'(found), 64'd1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    expq.delete();
    @(posedge clk); #1;
    check("abort_best_dist", 64'(best_dist), {{(64-DIST_W){1'b0}}, {DIST_W{1'b1}}});
    check("abort_flags", {60'd0, busy, done, hit, error}, 64'd0);
    check("abort_ready_idx", {47'd0, calc_ready, cand_idx}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    dist_mem[0] = 7;
    run(1, '0, -1, 0);

    for (int t = 0; t < 30; t++) begin
      n = $urandom_range(1, 20);
      for (int i = 0; i < n; i++) begin
        tmp = {$urandom(), $urandom()};
        dist_mem[i] = ($urandom_range(0, 3) == 0) ? tmp[DIST_W-1:0] : DIST_W'($urandom_range(0, 50));
      end
      thr = ($urandom_range(0, 2) == 0) ? DIST_W'($urandom_range(0, 20)) : '0;
      stall = ($urandom_range(0, 7) == 0) ? $urandom_range(0, n - 1) : -1;
      run(n, thr, stall, bit'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
